// File: rtl/spart_pkg.sv
// Shared bus addresses, driver states and baud divisor arithmetic for the SPART driver.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    WR_DBL,
    WR_DBH,
    WAIT_RDA,
    RD_RX,
    WAIT_TBR,
    WR_TX
  } drv_state_t;

  // cfg selects 4800 * 2^cfg baud; result truncates like the spart counter expects.
  function automatic logic [15:0] baud_div(input logic [1:0] cfg, input int unsigned clk_hz);
    int unsigned baud;
    int unsigned quot;
    baud = 32'd4800 << cfg;
    quot = clk_hz / (32'd16 * baud);
    return 16'(quot - 32'd1);
  endfunction

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs; two cycles of latency, no handshake.
module spart_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // No reset: the flops keep tracking the switches while reset is held, so the
  // first cycle after release already sees the real setting.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/spart_driver.sv
// SPART processor-side driver: programs the baud divisor, then echoes each received byte.
// Bus strobes are registered and aligned with the FSM state; waits on rda/tbr stall the loop.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_char
);

  drv_state_t state, state_next;
  logic [1:0] cfg_sync, cfg_q, cfg_next;
  logic       loaded;
  logic [15:0] div_next;
  logic [7:0] dout, dout_next;
  logic       iocs_next, iorw_next;
  logic [1:0] ioaddr_next;

  spart_sync2 #(.WIDTH(2)) u_cfg_sync (
    .clk (clk),
    .d   (br_cfg),
    .q   (cfg_sync)
  );

  always_comb begin
    state_next = state;
    cfg_next   = cfg_q;
    case (state)
      // The first cycle out of reset only captures the switch setting.
      WR_DBL: begin
        if (!loaded) cfg_next = cfg_sync;
        else         state_next = WR_DBH;
      end
      WR_DBH: state_next = WAIT_RDA;
      WAIT_RDA: begin
        if (cfg_sync != cfg_q) begin
          cfg_next   = cfg_sync;
          state_next = WR_DBL;
        end else if (rda) begin
          state_next = RD_RX;
        end
      end
      RD_RX:    state_next = WAIT_TBR;
      WAIT_TBR: if (tbr) state_next = WR_TX;
      WR_TX:    state_next = WAIT_RDA;
      default:  state_next = WR_DBL;
    endcase
  end

  // Bus registers are loaded from the decode of the next state so they line up with it.
  always_comb begin
    div_next    = baud_div(cfg_next, CLK_HZ);
    iocs_next   = 1'b0;
    iorw_next   = 1'b1;
    ioaddr_next = ADDR_BUF;
    dout_next   = 8'h00;
    case (state_next)
      WR_DBL: begin
        iocs_next   = 1'b1;
        iorw_next   = 1'b0;
        ioaddr_next = ADDR_DBL;
        dout_next   = div_next[7:0];
      end
      WR_DBH: begin
        iocs_next   = 1'b1;
        iorw_next   = 1'b0;
        ioaddr_next = ADDR_DBH;
        dout_next   = div_next[15:8];
      end
      RD_RX: iocs_next = 1'b1;
      WR_TX: begin
        iocs_next = 1'b1;
        iorw_next = 1'b0;
        dout_next = rx_char;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WR_DBL;
      loaded  <= 1'b0;
      cfg_q   <= 2'b00;
      iocs    <= 1'b0;
      iorw    <= 1'b1;
      ioaddr  <= ADDR_BUF;
      dout    <= 8'h00;
      rx_char <= 8'h00;
    end else begin
      state  <= state_next;
      loaded <= 1'b1;
      cfg_q  <= cfg_next;
      iocs   <= iocs_next;
      iorw   <= iorw_next;
      ioaddr <= ioaddr_next;
      dout   <= dout_next;
      if (state == RD_RX) rx_char <= databus;
    end
  end

  assign databus = (iocs && !iorw) ? dout : 8'hzz;

endmodule
